// File: rtl/irq_controller_if.sv
// Bus and core-handshake bundle for irq_controller.
// The master side is the bus initiator and the core. The slave side is the controller.
interface irq_controller_if;
    logic [31:0] data_bus_addr;
    logic [1:0]  data_bus_mode;
    logic        irq_req;
    logic [2:0]  irq_id;
    logic        irq_ack;
    logic        irq_done;

    modport master (
        output data_bus_addr,
        output data_bus_mode,
        output irq_ack,
        output irq_done,
        input  irq_req,
        input  irq_id
    );

    modport slave (
        input  data_bus_addr,
        input  data_bus_mode,
        input  irq_ack,
        input  irq_done,
        output irq_req,
        output irq_id
    );
endinterface

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller.
// Raw lines are synchronised and rising edges are latched into pending bits.
// Pending bits are masked by ENABLE. The lowest eligible index is offered to
// the core through a req/ack/done handshake, one interrupt at a time.
module irq_controller #(
    parameter logic [31:0] base_address = 32'h4090,
    parameter int          NUM_SRC      = 5
) (
    input  logic               clk,
    input  logic               reset,
    inout  wire  [31:0]        data_bus_data,
    input  logic [NUM_SRC-1:0] irq_sources,
    irq_controller_if.slave    bus
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_ACTIVE = 2'd2} state_t;

    state_t             state_reg, state_next;
    logic [2:0]         id_reg, id_next;
    logic [NUM_SRC-1:0] enable_reg;
    logic [NUM_SRC-1:0] pending_reg, pending_next;
    logic               gen_reg;
    logic [NUM_SRC-1:0] sync1_reg, sync2_reg, prev_reg;
    logic [NUM_SRC-1:0] rise;

    logic [31:0]        offset;
    logic               hit;
    logic [1:0]         reg_sel;
    logic               rd_en, wr_en;
    logic               wr_enable, wr_pending, wr_ctrl;
    logic [31:0]        rdata;

    logic [NUM_SRC-1:0] cand, cand_shift;
    logic               any_cand;
    logic [2:0]         winner;
    logic               cur_eligible;

    // Address decode: a 16-byte window, low two address bits ignored.
    assign offset     = bus.data_bus_addr - base_address;
    assign hit        = (offset[31:4] == 28'd0);
    assign reg_sel    = offset[3:2];
    assign rd_en      = hit && (bus.data_bus_mode == 2'b01);
    assign wr_en      = hit && (bus.data_bus_mode == 2'b10);
    assign wr_enable  = wr_en && (reg_sel == 2'd0);
    assign wr_pending = wr_en && (reg_sel == 2'd1);
    assign wr_ctrl    = wr_en && (reg_sel == 2'd3);

    // Bits that carry no register data are sunk here.
    logic unused_bits;
    assign unused_bits = ^{offset[1:0], data_bus_data};

    // Input path: two synchroniser stages followed by a previous-value stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            prev_reg  <= '0;
        end else begin
            sync1_reg <= irq_sources;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign rise = sync2_reg & ~prev_reg;

    // Per-source pending update: set beats W1C, and W1C beats the ack clear.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        logic set_bit, w1c_bit, ack_bit;
        assign set_bit = rise[gi] | (wr_ctrl & data_bus_data[16 + gi]);
        assign w1c_bit = wr_pending & data_bus_data[gi];
        assign ack_bit = (state_reg == ST_REQ) & bus.irq_ack & (id_reg == 3'(gi));
        assign pending_next[gi] = set_bit | (pending_reg[gi] & ~w1c_bit & ~ack_bit);
    end

    // Software-visible registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            enable_reg  <= '0;
            gen_reg     <= 1'b0;
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
            if (wr_enable) enable_reg <= data_bus_data[NUM_SRC-1:0];
            if (wr_ctrl)   gen_reg    <= data_bus_data[0];
        end
    end

    assign cand       = pending_reg & enable_reg;
    assign cand_shift = cand >> id_reg;
    assign cur_eligible = cand_shift[0];

    // Fixed priority: the lowest set index wins.
    always_comb begin
        winner   = 3'd0;
        any_cand = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                winner   = 3'(i);
                any_cand = 1'b1;
            end
        end
    end

    // FSM state and the registered request index.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            id_reg    <= 3'd0;
        end else begin
            state_reg <= state_next;
            id_reg    <= id_next;
        end
    end

    // FSM next state. An ack in REQ takes priority over a withdrawal.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (gen_reg && any_cand) state_next = ST_REQ;
            ST_REQ: begin
                if (bus.irq_ack)                        state_next = ST_ACTIVE;
                else if (!cur_eligible || !gen_reg)     state_next = ST_IDLE;
            end
            ST_ACTIVE: if (bus.irq_done) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // FSM outputs. The index is captured only when a request is launched from IDLE.
    always_comb begin
        id_next = id_reg;
        if (state_reg == ST_IDLE && gen_reg && any_cand) id_next = winner;
    end

    assign bus.irq_req = (state_reg == ST_REQ);
    assign bus.irq_id  = id_reg;

    // Register read mux. Unused bits read as zero.
    always_comb begin
        rdata = 32'd0;
        case (reg_sel)
            2'd0: rdata[NUM_SRC-1:0] = enable_reg;
            2'd1: rdata[NUM_SRC-1:0] = pending_reg;
            2'd2: begin
                rdata[2:0] = id_reg;
                rdata[8]   = (state_reg == ST_REQ);
                rdata[9]   = (state_reg == ST_ACTIVE);
            end
            default: rdata[0] = gen_reg;
        endcase
    end

    assign data_bus_data = rd_en ? rdata : 32'bz;
endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller.
// The driver issues one bus/handshake cycle at a time. It queues the outputs
// the reference model predicts for that cycle. A monitor pops the queue on
// each falling edge and compares against the DUT.
module tb_irq_controller;
    localparam int          N    = 5;
    localparam logic [31:0] BASE = 32'h4090;
    localparam int          S_IDLE = 0, S_REQ = 1, S_ACTIVE = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] irq_sources;
    wire  [31:0]  data_bus_data;
    logic         tb_drive;
    logic [31:0]  tb_wdata;

    assign data_bus_data = tb_drive ? tb_wdata : 32'bz;
    pullup (data_bus_data);

    irq_controller_if bus_if ();

    irq_controller #(.base_address(BASE), .NUM_SRC(N)) dut (
        .clk(clk),
        .reset(reset),
        .data_bus_data(data_bus_data),
        .irq_sources(irq_sources),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [2:0]  id;
        logic        chk_bus;
        logic [31:0] bus_val;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    // Reference model state
    logic [N-1:0] m_en, m_pend, h1, h2, h3, cur_src;
    logic         m_gen;
    int           m_st;
    logic [2:0]   m_id;

    function automatic logic [31:0] read_model(input logic [31:0] addr);
        logic [31:0] off;
        logic [31:0] r;
        off = addr - BASE;
        r = 32'd0;
        if (off >= 32'd16) return 32'hFFFF_FFFF;   // undriven bus floats to the pull-up
        case (off[3:2])
            2'd0: r = 32'(m_en);
            2'd1: r = 32'(m_pend);
            2'd2: r = {22'd0, (m_st == S_ACTIVE), (m_st == S_REQ), 5'd0, m_id};
            default: r = {31'd0, m_gen};
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_en = '0; m_pend = '0; m_gen = 1'b0; m_st = S_IDLE; m_id = 3'd0;
        h1 = '0; h2 = '0; h3 = '0;
    endtask

    // One clock edge of the controller, straight from the behavioural rules.
    task automatic model_edge(input logic rst, input logic [1:0] mode, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [N-1:0] src,
                              input logic ack, input logic done);
        logic [31:0]  off;
        logic         wr;
        logic [N-1:0] rise, sw, w1c, ackclr, cand;
        if (rst) begin
            model_reset();
            return;
        end
        off    = addr - BASE;
        wr     = (mode == 2'b10) && (off < 32'd16);
        rise   = h2 & ~h3;
        sw     = (wr && off[3:2] == 2'd3) ? wd[16 +: N] : '0;
        w1c    = (wr && off[3:2] == 2'd1) ? wd[N-1:0] : '0;
        ackclr = (m_st == S_REQ && ack) ? (N'(1) << m_id) : '0;
        cand   = m_pend & m_en;
        case (m_st)
            S_IDLE: if (m_gen && cand != '0) begin
                m_st = S_REQ;
                for (int i = N - 1; i >= 0; i--) if (cand[i]) m_id = 3'(i);
            end
            S_REQ: begin
                if (ack) m_st = S_ACTIVE;
                else if (((cand >> m_id) & N'(1)) == '0 || !m_gen) m_st = S_IDLE;
            end
            default: if (done) m_st = S_IDLE;
        endcase
        m_pend = (m_pend & ~w1c & ~ackclr) | rise | sw;
        if (wr && off[3:2] == 2'd0) m_en  = wd[N-1:0];
        if (wr && off[3:2] == 2'd3) m_gen = wd[0];
        h3 = h2; h2 = h1; h1 = src;
    endtask

    // Drive one cycle, queue its expectation, then advance across the edge.
    task automatic cycle(input logic [1:0] mode, input logic [31:0] addr, input logic [31:0] wd,
                         input logic ack, input logic done, input logic rst);
        exp_t e;
        reset                = rst;
        bus_if.data_bus_mode = mode;
        bus_if.data_bus_addr = addr;
        bus_if.irq_ack       = ack;
        bus_if.irq_done      = done;
        tb_drive             = (mode == 2'b10);
        tb_wdata             = wd;
        irq_sources          = cur_src;
        e.req     = (m_st == S_REQ);
        e.id      = m_id;
        e.chk_bus = (mode != 2'b10);
        e.bus_val = (mode == 2'b01) ? read_model(addr) : 32'hFFFF_FFFF;
        sb.push_back(e);
        @(posedge clk);
        model_edge(rst, mode, addr, wd, cur_src, ack, done);
        #1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) cycle(2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        cycle(2'b10, BASE + off, d, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic rd(input logic [31:0] off);
        cycle(2'b01, BASE + off, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic do_ack();
        cycle(2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    endtask
    task automatic do_done();
        cycle(2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    endtask

    // Monitor: compares every presented cycle against the queued prediction.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                checks++;
                if (bus_if.irq_req !== mon_e.req || bus_if.irq_id !== mon_e.id) begin
                    failures++;
                    $display("FAIL irq_out got req=%0b id=%0d expected req=%0b id=%0d at %0t",
                             bus_if.irq_req, bus_if.irq_id, mon_e.req, mon_e.id, $time);
                end
                if (mon_e.chk_bus) begin
                    checks++;
                    if (data_bus_data !== mon_e.bus_val) begin
                        failures++;
                        $display("FAIL bus_data addr=%h got %h expected %h at %0t",
                                 bus_if.data_bus_addr, data_bus_data, mon_e.bus_val, $time);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d;
        logic [1:0]  md;
        int          r;
        cur_src = '0;
        reset = 1'b1; tb_drive = 1'b0; tb_wdata = '0; irq_sources = '0;
        bus_if.data_bus_mode = 2'b00; bus_if.data_bus_addr = '0;
        bus_if.irq_ack = 1'b0; bus_if.irq_done = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        // Reset state, then the basic single-source request
        rd(32'h0); rd(32'h4); rd(32'h8); rd(32'hC);
        wr(32'h0, 32'h1F); wr(32'hC, 32'h1);
        cur_src = 5'b00100; tick(1); cur_src = '0;
        tick(1); rd(32'h4); rd(32'h8); tick(1);
        do_ack(); rd(32'h8); do_done(); tick(1);
        // Two simultaneous sources: priority then follow-up request
        cur_src = 5'b01010; tick(1); cur_src = '0;
        tick(4); do_ack(); tick(1); do_done(); tick(1); rd(32'h8);
        do_ack(); rd(32'h4); do_done(); tick(1);
        // Withdrawal by W1C while requesting
        cur_src = 5'b10000; tick(1); cur_src = '0;
        tick(4); wr(32'h4, 32'h10); tick(1); rd(32'h8); tick(1);
        // W1C coinciding with a hardware set on the same source
        wr(32'hC, 32'h0010_0001); tick(2);
        cur_src = 5'b10000; tick(1); tick(1);
        wr(32'h4, 32'h10); rd(32'h4); cur_src = '0;
        do_ack(); do_done(); tick(2);
        // Global enable off: pending latches, no request until re-enabled
        wr(32'hC, 32'h0);
        cur_src = 5'b00001; tick(1); cur_src = '0;
        tick(3); rd(32'h4); wr(32'hC, 32'h1); tick(1); rd(32'h8);
        do_ack(); do_done(); tick(1);
        // Software trigger and unmapped read
        wr(32'h0, 32'h02); wr(32'hC, 32'h0002_0001); tick(2); rd(32'h8);
        rd(32'h10); cycle(2'b11, BASE, 32'd0, 1'b0, 1'b0, 1'b0);
        // Reset while ACTIVE with pending bits outstanding
        do_ack(); wr(32'hC, 32'h000A_0001); rd(32'h4); rd(32'h8);
        cycle(2'b00, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1);
        rd(32'h0); rd(32'h4); rd(32'h8); rd(32'hC);
        do_done(); tick(1); rd(32'h8);
        // Randomised traffic
        wr(32'h0, 32'h1F); wr(32'hC, 32'h1);
        for (int k = 0; k < 2000; k++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) cur_src[b] = ~cur_src[b];
            r = int'($urandom_range(0, 5));
            if (r < 4) a = BASE + 32'(4 * r) + 32'($urandom_range(0, 3));
            else if (r == 4) a = BASE + 32'h10;
            else a = BASE - 32'h4;
            r = int'($urandom_range(0, 9));
            md = (r < 4) ? 2'b01 : (r < 6) ? 2'b10 : (r == 6) ? 2'b11 : 2'b00;
            d = $urandom;
            if (a - BASE == 32'hC || (a - BASE) >> 2 == 32'd3) begin
                d = d & 32'h001F_0000;
                if ($urandom_range(0, 1) == 0) d = d & 32'h0001_0000;
                d[0] = ($urandom_range(0, 9) != 0);
            end
            cycle(md, a, d, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 599) == 0));
        end
        tick(2);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d left expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Memory-mapped interrupt controller on the shared data bus.
- Sits between the raw interrupt lines (int_ext1, int_ext2, tim1..tim3 irq) and the datapath core.
- Latches rising edges into pending bits and masks them with per-source enables.
- Presents one request at a time, by fixed priority, to the core through a req/ack/done handshake. Nesting is not supported.

Parameters:
base_address, 32'h4090, byte address of register block (4 word registers, base+0x0..base+0xC)
NUM_SRC, 5, number of interrupt sources (1..8)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
data_bus_data  inout  32  shared data bus; driven only during a matching read, else high-Z
data_bus_addr  in  32  bus byte address
data_bus_mode  in  2  2'b00 idle, 2'b01 read, 2'b10 write, 2'b11 reserved (treated as idle)
irq_sources  in  NUM_SRC  raw interrupt lines, asynchronous or synchronous, level-high
irq_req  out  1  interrupt request to core
irq_id  out  3  index of requested / in-service source
irq_ack  in  1  core accepts the request (1-cycle pulse)
irq_done  in  1  core finished the handler (1-cycle pulse, on mret)

Behaviour:
- Register map (word addresses; byte lanes ignored; only full-word access):
  - +0x0 ENABLE: RW, bits [NUM_SRC-1:0].
  - +0x4 PENDING: reads pending bits. Write-1-to-clear.
  - +0x8 STATUS: RO. [2:0]=irq_id, [8]=irq_req, [9]=in service (ACTIVE).
  - +0xC CTRL: [0]=global enable, RW. Writing bit[16+i] sets pending[i] (software trigger). Read returns 0 in [31:16].
- Reads: combinational. data_bus_data is driven while mode==01 and the address matches. Unused bits read 0.
- Writes: take effect at the rising edge where mode==10 and the address matches.
- Input path, per source:
  - 2-flop synchronizer, then a previous-value flop. Edge = sync2 & ~prev.
  - A rise sampled at edge k sets pending at edge k+2.
- Pending update priority, per bit, at a single edge:
  - Set (hw edge or sw trigger) wins over W1C.
  - W1C wins over ack-clear.
- Reset: all flops clear. Outputs go to irq_req=0, irq_id=0. ENABLE=0, CTRL=0, pending=0, sync/prev=0, FSM=IDLE.
- Selection: cand = pending & ENABLE. The lowest set index wins (index 0 is highest priority).
- FSM:
  - IDLE: if global enable and cand!=0, go to REQ at the next edge.
    - irq_id <= winning index; irq_req <= 1. Both registered, so visible 1 cycle after pending becomes eligible.
  - REQ: irq_req=1 and irq_id held stable.
    - If irq_ack: pending[irq_id] cleared, go to ACTIVE, irq_req <= 0.
    - Else if pending[irq_id]&ENABLE[irq_id] goes 0 (W1C or disable), or global enable goes 0: go to IDLE, irq_req <= 0, irq_id unchanged.
    - A higher-priority source arriving in REQ does not preempt. irq_id stays fixed until ack or withdrawal.
  - ACTIVE: irq_req=0, irq_id holds the serviced index.
    - On irq_done: go to IDLE. A new REQ is possible at the earliest 1 edge later.
    - New pending bits accumulate while ACTIVE.
- Ignored inputs:
  - irq_ack in IDLE/ACTIVE.
  - irq_done in IDLE/REQ.
  - Simultaneous ack+done in REQ: ack is taken, done is ignored.
- A source edge arriving while its own pending is already set is lost (single-bit pending, no counting).
- A source held high generates exactly one pending event. It must go low then high again to generate another.
- Reset asserted in any state returns to IDLE at that edge. An in-flight ack/done is discarded.

Test Plan:
- Reset, write ENABLE=0x1F and CTRL=1, pulse irq_sources[2] high at edge k:
  - PENDING reads 0x04 after k+2.
  - irq_req=1, irq_id=2 after k+3.
  - STATUS reads 0x104.
- Sources 1 and 3 rise in the same cycle, enabled:
  - irq_id=1 first.
  - Ack, then done: next request irq_id=3 one cycle after done.
  - PENDING=0 after second ack.
- In REQ for id 4, write PENDING=0x10 (W1C): irq_req falls the next cycle, FSM IDLE, no ack needed.
  - Repeat with W1C and a hw edge on source 4 in the same cycle: pending stays 1.
- Global enable=0 with source 0 pulsed:
  - PENDING=0x01 and irq_req stays 0.
  - Set CTRL=1: irq_req=1, irq_id=0 after one cycle.
- Write CTRL=0x0002_0001 (sw trigger src 1) with ENABLE=0x02: irq_req=1, irq_id=1.
  - Bus read of unmapped address base+0x10: data_bus_data is high-Z.
- Assert reset during ACTIVE with pending=0x0A:
  - After reset edge: irq_req=0, irq_id=0, all registers read 0.
  - irq_done afterwards has no effect.
